// File: rtl/ldpc_fmt_pkg.sv
// Shared format definitions for the sign-magnitude / two's-complement converters.
package ldpc_fmt_pkg;

  localparam logic MODE_SM2TC = 1'b0;
  localparam logic MODE_TC2SM = 1'b1;

  // Most-negative two's-complement pattern (1 followed by zeros) for width w.
  function automatic logic [31:0] most_neg(input int w);
    return 32'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/sm_tc_conv.sv
// One-channel combinational converter between sign-magnitude and two's complement.
module sm_tc_conv
  import ldpc_fmt_pkg::*;
#(
  parameter int DATA_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  sat
);

  localparam logic [DATA_WIDTH-1:0] MN = DATA_WIDTH'(most_neg(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] neg_tc;
  logic [DATA_WIDTH-1:0] neg_sm;

  assign neg_tc = -din;
  assign neg_sm = -{1'b0, din[DATA_WIDTH-2:0]};

  always_comb begin
    dout = din;
    sat  = 1'b0;
    if (din[DATA_WIDTH-1]) begin
      if (mode == MODE_SM2TC) begin
        // Negative zero falls out naturally: -0 == 0.
        dout = neg_sm;
      end else if (din == MN) begin
        dout = '1;
        sat  = 1'b1;
      end else begin
        // Magnitude of a non-most-negative value never reaches the sign bit.
        dout = neg_tc | MN;
      end
    end
  end

endmodule

// File: rtl/sm_tc_pipe.sv
// Per-channel format conversion behind a two-entry skid buffer, with a clamping
// counter of saturated channels delivered downstream.
module sm_tc_pipe
  import ldpc_fmt_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_sat,
  output logic [CNT_WIDTH-1:0]         sat_count,
  input  logic                         clr_count
);

  localparam int WW  = NUM_CH * DATA_WIDTH;
  localparam int PCW = $clog2(NUM_CH + 1);
  localparam int SW  = CNT_WIDTH + PCW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WW-1:0]        conv_data;
  logic [NUM_CH-1:0]    conv_sat;

  logic                 main_vld_q, main_vld_d;
  logic [WW-1:0]        main_data_q, main_data_d;
  logic [NUM_CH-1:0]    main_sat_q, main_sat_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [WW-1:0]        skid_data_q, skid_data_d;
  logic [NUM_CH-1:0]    skid_sat_q, skid_sat_d;
  logic                 in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  logic                 in_fire, out_fire;
  logic [PCW-1:0]       sat_pop;
  logic [SW-1:0]        sat_sum;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_conv
    sm_tc_conv #(.DATA_WIDTH(DATA_WIDTH)) u_conv (
      .din  (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .mode (in_mode),
      .dout (conv_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .sat  (conv_sat[k])
    );
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_vld_q & out_ready;

  always_comb begin
    sat_pop = '0;
    for (int k = 0; k < NUM_CH; k++) sat_pop = sat_pop + PCW'(main_sat_q[k]);
  end

  assign sat_sum = SW'(sat_count_q) + SW'(sat_pop);

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_sat_d  = main_sat_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_sat_d  = skid_sat_q;
    sat_count_d = sat_count_q;

    if (!main_vld_q || out_fire) begin
      // Main slot frees up: older skid word goes first; in_ready is low then.
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = skid_data_q;
        main_sat_d  = skid_sat_q;
        skid_vld_d  = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) begin
          main_data_d = conv_data;
          main_sat_d  = conv_sat;
        end
      end
    end else if (in_fire) begin
      skid_vld_d  = 1'b1;
      skid_data_d = conv_data;
      skid_sat_d  = conv_sat;
    end

    in_ready_d = ~skid_vld_d;

    if (clr_count) begin
      sat_count_d = '0;
    end else if (out_fire) begin
      sat_count_d = (sat_sum > SW'(CNT_MAX)) ? CNT_MAX : sat_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_sat_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sat_q  <= '0;
      in_ready_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_sat_q  <= main_sat_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_sat_q  <= skid_sat_d;
      in_ready_q  <= in_ready_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_data_q;
  assign out_sat   = main_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_sm_tc_pipe.sv
// Bench for sm_tc_pipe: queue-based reference model checked every cycle, plus
// directed literal scenarios and a randomized valid/ready/reset phase.
module tb_sm_tc_pipe;

  localparam int DW   = 5;
  localparam int NC   = 4;
  localparam int CW   = 3;
  localparam int HALF = 1 << (DW - 1);
  localparam int FULL = 1 << DW;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_mode;
  logic [NC*DW-1:0] in_data;
  logic             out_valid, out_ready;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]    out_sat;
  logic [CW-1:0]    sat_count;
  logic             clr_count;

  always #5 clk = ~clk;

  sm_tc_pipe #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .clr_count(clr_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion from the number-format definitions, one channel at a time.
  function automatic void conv_word(input logic [NC*DW-1:0] din, input logic mode,
                                    output logic [NC*DW-1:0] dout, output logic [NC-1:0] sat);
    dout = '0;
    sat  = '0;
    for (int k = 0; k < NC; k++) begin
      int x, o;
      x = int'(din[k*DW +: DW]);
      if (mode == 1'b0) begin
        o = (x >= HALF) ? (FULL - (x - HALF)) % FULL : x;
      end else if (x == HALF) begin
        o = FULL - 1;
        sat[k] = 1'b1;
      end else if (x > HALF) begin
        o = HALF + (FULL - x);
      end else begin
        o = x;
      end
      dout[k*DW +: DW] = o[DW-1:0];
    end
  endfunction

  typedef struct {
    logic [NC*DW-1:0] d;
    logic [NC-1:0]    s;
  } ent_t;

  ent_t q[$];
  int   m_cnt   = 0;
  bit   m_rdy   = 0;
  bit   m_in_rst = 1;
  int   n_out   = 0;
  bit   armed   = 0;

  // Model: FIFO of at most two words; ready whenever fewer than two are held.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt    = 0;
      m_rdy    = 0;
      m_in_rst = 1;
    end else begin
      bit   inf, outf;
      ent_t e;
      inf  = in_valid && m_rdy;
      outf = (q.size() > 0) && out_ready;
      if (outf) begin
        m_cnt += $countones(q[0].s);
        if (m_cnt > CMAX) m_cnt = CMAX;
        void'(q.pop_front());
        n_out++;
      end
      if (clr_count) m_cnt = 0;
      if (inf) begin
        conv_word(in_data, in_mode, e.d, e.s);
        q.push_back(e);
      end
      m_rdy    = q.size() < 2;
      m_in_rst = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, m_rdy);
      chk("sat_count", sat_count, m_cnt);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_sat", out_sat, q[0].s);
      end else if (m_in_rst) begin
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
      end
    end
  end

  function automatic logic [NC*DW-1:0] pack4(input logic [DW-1:0] c3, input logic [DW-1:0] c2,
                                             input logic [DW-1:0] c1, input logic [DW-1:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present each word until accepted; bounded by a cycle budget.
  task automatic send_words(input logic [NC*DW-1:0] w[$], input logic mode);
    int i = 0;
    int budget = 0;
    while (i < w.size() && budget < 200) begin
      bit rb;
      in_valid = 1'b1;
      in_mode  = mode;
      in_data  = w[i];
      rb = in_ready;
      tick();
      if (rb) i++;
      budget++;
    end
    in_valid = 1'b0;
    chk("send_budget", i, w.size());
  endtask

  initial begin
    logic [NC*DW-1:0] w[$];
    logic [NC*DW-1:0] sat2;
    int low_cnt, i, c;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    out_ready = 1'b0; clr_count = 1'b0;
    tick();
    tick();
    armed = 1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_sat_count", sat_count, 0);
    chk("reset_out_data", out_data, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", in_ready, 1);

    // Sign-magnitude to two's complement, including negative zero.
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 1'b0;
    in_data = pack4(5'b11111, 5'b10000, 5'b00101, 5'b10011);
    tick();
    in_valid = 1'b0;
    chk("m0_data", out_data, pack4(5'b10001, 5'b00000, 5'b00101, 5'b11101));
    chk("m0_sat", out_sat, 4'b0000);
    tick();

    // Two's complement to sign-magnitude, including most-negative saturation.
    in_valid = 1'b1; in_mode = 1'b1;
    in_data = pack4(5'b00000, 5'b01111, 5'b11101, 5'b10000);
    tick();
    in_valid = 1'b0;
    chk("m1_data", out_data, pack4(5'b00000, 5'b01111, 5'b10011, 5'b11111));
    chk("m1_sat", out_sat, 4'b0001);
    tick();
    chk("m1_count", sat_count, 1);

    // Five words of two saturated channels each: 1+2+2+2+2+2 clamps at 7.
    sat2 = pack4(5'b00010, 5'b10000, 5'b00001, 5'b10000);
    w.delete();
    repeat (5) w.push_back(sat2);
    send_words(w, 1'b1);
    tick();
    tick();
    chk("count_clamp", sat_count, 7);
    tick();
    chk("count_hold", sat_count, 7);

    // Clear coincides with the output transfer of a saturating word.
    in_valid = 1'b1; in_mode = 1'b1; in_data = sat2;
    tick();
    in_valid = 1'b0; clr_count = 1'b1;
    chk("clr_pre_valid", out_valid, 1);
    tick();
    clr_count = 1'b0;
    chk("clr_priority", sat_count, 0);
    tick();

    // Ten back-to-back words; out_ready low on cycles 3..5 stalls three edges,
    // so the skid stays occupied (in_ready low) for exactly those three cycles.
    n_out = 0; i = 0; c = 0; low_cnt = 0;
    w.delete();
    for (int k = 0; k < 10; k++) w.push_back(NC*DW'($urandom));
    while ((i < 10 || n_out < 10) && c < 60) begin
      bit rb;
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (i < 10);
      in_mode   = c[0];
      in_data   = (i < 10) ? w[i] : '0;
      rb = in_ready;
      tick();
      if (in_valid && rb) i++;
      if (!in_ready) low_cnt++;
      c++;
    end
    in_valid = 1'b0;
    chk("b2b_sent", i, 10);
    chk("b2b_received", n_out, 10);
    chk("b2b_ready_low", low_cnt, 3);

    // Reset with both entries occupied discards them.
    out_ready = 1'b0;
    w.delete();
    w.push_back(sat2);
    w.push_back(pack4(5'b00001, 5'b00010, 5'b00011, 5'b00100));
    send_words(w, 1'b1);
    chk("full_ready_low", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_count", sat_count, 0);
    out_ready = 1'b1;
    tick();
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_no_out", out_valid, 0);

    // Randomized traffic, clears and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [NC*DW-1:0] d;
      for (int k = 0; k < NC; k++) begin
        logic [DW-1:0] ch;
        ch = DW'($urandom);
        if ($urandom_range(3) == 0) ch = DW'(HALF);
        d[k*DW +: DW] = ch;
      end
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_mode   = 1'($urandom);
      in_data   = d;
      clr_count = ($urandom_range(49) == 0);
      rst       = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; clr_count = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
